// File: rtl/rch_pkg.sv
// Shared definitions for the redundancy-checker table updater: ST codes,
// updater FSM encoding and table sizing.
package rch_pkg;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_ORIG = 2'b01;
  localparam logic [1:0] ST_RED  = 2'b10;

  localparam int unsigned STEP_RANGE_DEF    = 128;
  localparam int unsigned MAX_LIFM_RSIZ_DEF = 3;
  localparam int unsigned TBL_ENTRIES       = MAX_LIFM_RSIZ_DEF * STEP_RANGE_DEF;

  typedef enum logic [1:0] {
    UPD_IDLE,
    UPD_SRC,
    UPD_DEST
  } upd_state_e;

  function automatic int unsigned tbl_entries(input int unsigned rsiz, input int unsigned step);
    return rsiz * step;
  endfunction

endpackage

// File: rtl/rch_result_fifo.sv
// Synchronous circular-buffer FIFO with wrap-around pointers, a count and a
// synchronous flush. DEPTH must be a power of two.
module rch_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds data only; validity is tracked by the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rch_table_updater.sv
// Buffers per-pair MT/ST results and serialises source/destination writes onto
// the shared table port. Optional macro RCH_UPD_STATS_EN adds red_cnt.
module rch_table_updater
  import rch_pkg::*;
#(
  parameter int STEP_RANGE    = 128,
  parameter int MAX_LIFM_RSIZ = 3,
  parameter int ITER_WIDTH    = 9,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ITER_WIDTH-1:0] src_idx,
  input  logic [ITER_WIDTH-1:0] dest_idx,
  input  logic                  dest_en,
  input  logic [STEP_RANGE-1:0] n_src_mt,
  input  logic [STEP_RANGE-1:0] n_dest_mt,
  input  logic [1:0]            n_src_st,
  input  logic [1:0]            n_dest_st,
  input  logic                  tbl_busy,
  output logic                  tbl_we,
  output logic [ITER_WIDTH-1:0] tbl_addr,
  output logic [STEP_RANGE-1:0] tbl_mt,
  output logic [1:0]            tbl_st,
  output logic                  idle,
  output logic                  idx_err
`ifdef RCH_UPD_STATS_EN
  ,
  output logic [ITER_WIDTH:0]   red_cnt
`endif
);

  localparam int unsigned TBL_LIMIT = tbl_entries(MAX_LIFM_RSIZ, STEP_RANGE);
  localparam int REC_W  = 2 * ITER_WIDTH + 2 * STEP_RANGE + 5;
  localparam int WORK_W = ITER_WIDTH + STEP_RANGE + 3;

  logic [REC_W-1:0]      in_rec;
  logic [REC_W-1:0]      head_rec;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;

  logic                  h_dest_en;
  logic [ITER_WIDTH-1:0] h_src_idx;
  logic [ITER_WIDTH-1:0] h_dest_idx;
  logic [STEP_RANGE-1:0] h_src_mt;
  logic [STEP_RANGE-1:0] h_dest_mt;
  logic [1:0]            h_src_st;
  logic [1:0]            h_dest_st;

  logic                  w_dest_en;
  logic [ITER_WIDTH-1:0] w_dest_idx;
  logic [STEP_RANGE-1:0] w_dest_mt;
  logic [1:0]            w_dest_st;

  upd_state_e            state_q, state_d;
  logic [WORK_W-1:0]     work_q, work_d;
  logic [ITER_WIDTH-1:0] tbl_addr_q, tbl_addr_d;
  logic [STEP_RANGE-1:0] tbl_mt_q, tbl_mt_d;
  logic [1:0]            tbl_st_q, tbl_st_d;
  logic                  idx_err_q, idx_err_d;

  logic                  writing;
  logic                  advance;
  logic                  addr_ok;

  assign in_rec = {dest_en, src_idx, dest_idx, n_src_mt, n_dest_mt, n_src_st, n_dest_st};
  assign {h_dest_en, h_src_idx, h_dest_idx, h_src_mt, h_dest_mt, h_src_st, h_dest_st} = head_rec;
  assign {w_dest_en, w_dest_idx, w_dest_mt, w_dest_st} = work_q;

  rch_result_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_rec),
    .rdata (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign idle     = fifo_empty && (state_q == UPD_IDLE);
  assign writing  = (state_q == UPD_SRC) || (state_q == UPD_DEST);
  assign advance  = writing && !tbl_busy && !clear;
  assign addr_ok  = (32'(tbl_addr_q) < TBL_LIMIT);
  assign tbl_we   = advance && addr_ok && !reset;
  assign tbl_addr = tbl_addr_q;
  assign tbl_mt   = tbl_mt_q;
  assign tbl_st   = tbl_st_q;
  assign idx_err  = idx_err_q;

  // Only the destination half of a record needs to outlive the pop.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    tbl_addr_d = tbl_addr_q;
    tbl_mt_d   = tbl_mt_q;
    tbl_st_d   = tbl_st_q;
    pop        = 1'b0;
    if (clear) begin
      state_d    = UPD_IDLE;
      work_d     = '0;
      tbl_addr_d = '0;
      tbl_mt_d   = '0;
      tbl_st_d   = '0;
    end else begin
      case (state_q)
        UPD_IDLE: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            work_d     = {h_dest_en, h_dest_idx, h_dest_mt, h_dest_st};
            tbl_addr_d = h_src_idx;
            tbl_mt_d   = h_src_mt;
            tbl_st_d   = h_src_st;
            state_d    = UPD_SRC;
          end
        end
        UPD_SRC: begin
          if (!tbl_busy) begin
            if (w_dest_en) begin
              tbl_addr_d = w_dest_idx;
              tbl_mt_d   = w_dest_mt;
              tbl_st_d   = w_dest_st;
              state_d    = UPD_DEST;
            end else begin
              state_d = UPD_IDLE;
            end
          end
        end
        UPD_DEST: begin
          if (!tbl_busy) state_d = UPD_IDLE;
        end
        default: state_d = UPD_IDLE;
      endcase
    end
  end

  always_comb begin
    idx_err_d = idx_err_q;
    if (clear) idx_err_d = 1'b0;
    else if (advance && !addr_ok) idx_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= UPD_IDLE;
      work_q     <= '0;
      tbl_addr_q <= '0;
      tbl_mt_q   <= '0;
      tbl_st_q   <= '0;
      idx_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      tbl_addr_q <= tbl_addr_d;
      tbl_mt_q   <= tbl_mt_d;
      tbl_st_q   <= tbl_st_d;
      idx_err_q  <= idx_err_d;
    end
  end

`ifdef RCH_UPD_STATS_EN
  logic [ITER_WIDTH:0] red_cnt_q, red_cnt_d;

  always_comb begin
    red_cnt_d = red_cnt_q;
    if (clear) red_cnt_d = '0;
    else if (tbl_we && (tbl_st_q == ST_RED) && (red_cnt_q != '1)) red_cnt_d = red_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) red_cnt_q <= '0;
    else       red_cnt_q <= red_cnt_d;
  end

  assign red_cnt = red_cnt_q;
`endif

endmodule

// File: tb/tb_rch_table_updater.sv
// Directed self-checking bench for rch_table_updater; covers the stats
// counter too when RCH_UPD_STATS_EN is defined.
module tb_rch_table_updater;
  import rch_pkg::*;

  localparam int STEP_RANGE    = 128;
  localparam int MAX_LIFM_RSIZ = 3;
  localparam int ITER_WIDTH    = 9;
  localparam int FIFO_DEPTH    = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  clear;
  logic                  in_valid;
  logic                  in_ready;
  logic [ITER_WIDTH-1:0] src_idx;
  logic [ITER_WIDTH-1:0] dest_idx;
  logic                  dest_en;
  logic [STEP_RANGE-1:0] n_src_mt;
  logic [STEP_RANGE-1:0] n_dest_mt;
  logic [1:0]            n_src_st;
  logic [1:0]            n_dest_st;
  logic                  tbl_busy;
  logic                  tbl_we;
  logic [ITER_WIDTH-1:0] tbl_addr;
  logic [STEP_RANGE-1:0] tbl_mt;
  logic [1:0]            tbl_st;
  logic                  idle;
  logic                  idx_err;
`ifdef RCH_UPD_STATS_EN
  logic [ITER_WIDTH:0]   red_cnt;
`endif

  int assert_cnt = 0;
  int fail_cnt   = 0;

  typedef struct {
    logic [ITER_WIDTH-1:0] addr;
    logic [1:0]            st;
    logic [STEP_RANGE-1:0] mt;
  } wr_t;

  wr_t wr_log[$];

  rch_table_updater #(
    .STEP_RANGE    (STEP_RANGE),
    .MAX_LIFM_RSIZ (MAX_LIFM_RSIZ),
    .ITER_WIDTH    (ITER_WIDTH),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src_idx   (src_idx),
    .dest_idx  (dest_idx),
    .dest_en   (dest_en),
    .n_src_mt  (n_src_mt),
    .n_dest_mt (n_dest_mt),
    .n_src_st  (n_src_st),
    .n_dest_st (n_dest_st),
    .tbl_busy  (tbl_busy),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_mt    (tbl_mt),
    .tbl_st    (tbl_st),
    .idle      (idle),
    .idx_err   (idx_err)
`ifdef RCH_UPD_STATS_EN
    ,
    .red_cnt   (red_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Table writes are captured mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (tbl_we === 1'b1) wr_log.push_back('{tbl_addr, tbl_st, tbl_mt});
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [STEP_RANGE-1:0] mt_pat(input logic [ITER_WIDTH-1:0] a);
    logic [22:0] pad;
    pad = 23'h5A5A5;
    return {4{pad, a}};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkWrite(input string tag, input int n, input logic [ITER_WIDTH-1:0] addr,
                            input logic [1:0] st, input logic [STEP_RANGE-1:0] mt);
    if (wr_log.size() > n) begin
      checkOutput({tag, "_addr"}, 128'(wr_log[n].addr), 128'(addr));
      checkOutput({tag, "_st"}, 128'(wr_log[n].st), 128'(st));
      checkOutput({tag, "_mt"}, wr_log[n].mt, mt);
    end else begin
      checkOutput({tag, "_present"}, 128'(wr_log.size()), 128'(n + 1));
    end
  endtask

  task automatic applyStimulus(input logic [ITER_WIDTH-1:0] s, input logic [ITER_WIDTH-1:0] d,
                               input logic de, input logic [STEP_RANGE-1:0] smt,
                               input logic [STEP_RANGE-1:0] dmt, input logic [1:0] sst,
                               input logic [1:0] dst);
    in_valid  = 1'b1;
    src_idx   = s;
    dest_idx  = d;
    dest_en   = de;
    n_src_mt  = smt;
    n_dest_mt = dmt;
    n_src_st  = sst;
    n_dest_st = dst;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      next_cycle();
      #1;
      if (idle === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_idle_reached"}, 128'(done), 128'(1));
  endtask

  initial begin
    bit acc;
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    src_idx   = '0;
    dest_idx  = '0;
    dest_en   = 1'b0;
    n_src_mt  = '0;
    n_dest_mt = '0;
    n_src_st  = '0;
    n_dest_st = '0;
    tbl_busy  = 1'b0;
    repeat (3) next_cycle();
    reset = 1'b0;
    #1;
    checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
    checkOutput("rst_we", 128'(tbl_we), 128'(0));
    checkOutput("rst_addr", 128'(tbl_addr), 128'(0));
    checkOutput("rst_mt", tbl_mt, 128'(0));
    checkOutput("rst_st", 128'(tbl_st), 128'(0));
    checkOutput("rst_idle", 128'(idle), 128'(1));
    checkOutput("rst_idx_err", 128'(idx_err), 128'(0));

    $display("[TB] single record, no stall");
    wr_log.delete();
    next_cycle();
    applyStimulus(9'd5, 9'd133, 1'b1, mt_pat(9'd5), mt_pat(9'd133), ST_RED, ST_ORIG);
    #1;
    checkOutput("one_in_ready", 128'(in_ready), 128'(1));
    next_cycle();
    in_valid = 1'b0;
    #1;
    checkOutput("one_we_t1", 128'(tbl_we), 128'(0));
    checkOutput("one_idle_t1", 128'(idle), 128'(0));
    next_cycle();
    #1;
    checkOutput("one_we_t2", 128'(tbl_we), 128'(1));
    checkOutput("one_addr_t2", 128'(tbl_addr), 128'(5));
    checkOutput("one_st_t2", 128'(tbl_st), 128'(ST_RED));
    checkOutput("one_mt_t2", tbl_mt, mt_pat(9'd5));
    next_cycle();
    #1;
    checkOutput("one_we_t3", 128'(tbl_we), 128'(1));
    checkOutput("one_addr_t3", 128'(tbl_addr), 128'(133));
    checkOutput("one_st_t3", 128'(tbl_st), 128'(ST_ORIG));
    checkOutput("one_mt_t3", tbl_mt, mt_pat(9'd133));
    next_cycle();
    #1;
    checkOutput("one_idle_t4", 128'(idle), 128'(1));
    checkOutput("one_we_t4", 128'(tbl_we), 128'(0));
    checkOutput("one_log_size", 128'(wr_log.size()), 128'(2));

    $display("[TB] same source and destination index");
    wr_log.delete();
    next_cycle();
    applyStimulus(9'd9, 9'd9, 1'b1, mt_pat(9'd1), mt_pat(9'd2), ST_RED, ST_ORIG);
    next_cycle();
    in_valid = 1'b0;
    wait_idle("same");
    checkOutput("same_log_size", 128'(wr_log.size()), 128'(2));
    checkWrite("same_w0", 0, 9'd9, ST_RED, mt_pat(9'd1));
    checkWrite("same_w1", 1, 9'd9, ST_ORIG, mt_pat(9'd2));

    $display("[TB] stall during source write");
    wr_log.delete();
    next_cycle();
    applyStimulus(9'd5, 9'd0, 1'b0, mt_pat(9'd5), '1, ST_RED, 2'b11);
    next_cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      tbl_busy = 1'b1;
      #1;
      checkOutput($sformatf("stall_we_%0d", i), 128'(tbl_we), 128'(0));
      checkOutput($sformatf("stall_addr_%0d", i), 128'(tbl_addr), 128'(5));
      checkOutput($sformatf("stall_st_%0d", i), 128'(tbl_st), 128'(ST_RED));
      checkOutput($sformatf("stall_mt_%0d", i), tbl_mt, mt_pat(9'd5));
    end
    next_cycle();
    tbl_busy = 1'b0;
    #1;
    checkOutput("stall_release_we", 128'(tbl_we), 128'(1));
    checkOutput("stall_release_addr", 128'(tbl_addr), 128'(5));
    next_cycle();
    #1;
    checkOutput("stall_after_we", 128'(tbl_we), 128'(0));
    checkOutput("stall_after_idle", 128'(idle), 128'(1));
    checkOutput("stall_log_size", 128'(wr_log.size()), 128'(1));

    $display("[TB] back-pressure with table port busy");
    wr_log.delete();
    tbl_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      applyStimulus(9'(20 + i), 9'd0, 1'b0, mt_pat(9'(20 + i)), '0, ST_ORIG, ST_NONE);
      #1;
      checkOutput($sformatf("bp_ready_%0d", i), 128'(in_ready), 128'(1));
    end
    next_cycle();
    applyStimulus(9'd25, 9'd0, 1'b0, mt_pat(9'd25), '0, ST_ORIG, ST_NONE);
    #1;
    checkOutput("bp_full_0", 128'(in_ready), 128'(0));
    next_cycle();
    #1;
    checkOutput("bp_full_1", 128'(in_ready), 128'(0));
    checkOutput("bp_no_write", 128'(wr_log.size()), 128'(0));
    next_cycle();
    tbl_busy = 1'b0;
    #1;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (in_ready === 1'b1) begin
        acc = 1'b1;
        break;
      end
      next_cycle();
      #1;
    end
    checkOutput("bp_accept", 128'(acc), 128'(1));
    next_cycle();
    in_valid = 1'b0;
    wait_idle("bp");
    checkOutput("bp_log_size", 128'(wr_log.size()), 128'(6));
    for (int i = 0; i < 6; i++) begin
      checkWrite($sformatf("bp_w%0d", i), i, 9'(20 + i), ST_ORIG, mt_pat(9'(20 + i)));
    end

    $display("[TB] out-of-range index");
    wr_log.delete();
    next_cycle();
    applyStimulus(9'd400, 9'd0, 1'b0, mt_pat(9'd1), '0, ST_ORIG, ST_NONE);
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    #1;
    checkOutput("range_we", 128'(tbl_we), 128'(0));
    next_cycle();
    #1;
    checkOutput("range_err", 128'(idx_err), 128'(1));
    checkOutput("range_idle", 128'(idle), 128'(1));
    next_cycle();
    applyStimulus(9'd7, 9'd0, 1'b0, mt_pat(9'd7), '0, ST_ORIG, ST_NONE);
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    #1;
    checkOutput("range_next_we", 128'(tbl_we), 128'(1));
    checkOutput("range_next_addr", 128'(tbl_addr), 128'(7));
    next_cycle();
    #1;
    checkOutput("range_err_sticky", 128'(idx_err), 128'(1));
    checkOutput("range_log_size", 128'(wr_log.size()), 128'(1));

    $display("[TB] clear during destination write");
    wr_log.delete();
    next_cycle();
    applyStimulus(9'd30, 9'd31, 1'b1, mt_pat(9'd30), mt_pat(9'd31), ST_ORIG, ST_ORIG);
    next_cycle();
    applyStimulus(9'd40, 9'd41, 1'b1, mt_pat(9'd40), mt_pat(9'd41), ST_ORIG, ST_ORIG);
    next_cycle();
    applyStimulus(9'd50, 9'd51, 1'b1, mt_pat(9'd50), mt_pat(9'd51), ST_ORIG, ST_ORIG);
    next_cycle();
    applyStimulus(9'd60, 9'd61, 1'b1, mt_pat(9'd60), mt_pat(9'd61), ST_ORIG, ST_ORIG);
    clear = 1'b1;
    #1;
    checkOutput("clr_we_same_cycle", 128'(tbl_we), 128'(0));
    checkOutput("clr_addr_dest", 128'(tbl_addr), 128'(31));
    next_cycle();
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("clr_we_next", 128'(tbl_we), 128'(0));
    checkOutput("clr_idle", 128'(idle), 128'(1));
    checkOutput("clr_idx_err", 128'(idx_err), 128'(0));
    checkOutput("clr_in_ready", 128'(in_ready), 128'(1));
    repeat (5) next_cycle();
    checkOutput("clr_log_size", 128'(wr_log.size()), 128'(1));
    checkWrite("clr_w0", 0, 9'd30, ST_ORIG, mt_pat(9'd30));

    $display("[TB] reset during source write");
    wr_log.delete();
    next_cycle();
    applyStimulus(9'd11, 9'd0, 1'b0, mt_pat(9'd11), '0, ST_RED, ST_NONE);
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    reset = 1'b1;
    #1;
    checkOutput("rstw_we", 128'(tbl_we), 128'(0));
    next_cycle();
    reset = 1'b0;
    #1;
    checkOutput("rstw_idle", 128'(idle), 128'(1));
    checkOutput("rstw_addr", 128'(tbl_addr), 128'(0));
    repeat (3) next_cycle();
    checkOutput("rstw_log_size", 128'(wr_log.size()), 128'(0));

`ifdef RCH_UPD_STATS_EN
    $display("[TB] redundant-entry counter");
    next_cycle();
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    #1;
    checkOutput("stats_cleared", 128'(red_cnt), 128'(0));
    applyStimulus(9'd1, 9'd2, 1'b1, mt_pat(9'd1), mt_pat(9'd2), ST_RED, ST_RED);
    next_cycle();
    applyStimulus(9'd3, 9'd4, 1'b0, mt_pat(9'd3), mt_pat(9'd4), ST_RED, ST_RED);
    next_cycle();
    applyStimulus(9'd5, 9'd6, 1'b1, mt_pat(9'd5), mt_pat(9'd6), ST_ORIG, ST_RED);
    next_cycle();
    in_valid = 1'b0;
    wait_idle("stats");
    checkOutput("stats_red_cnt", 128'(red_cnt), 128'(4));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
